snake_target_placer: RTL

//  Parametrised successor to the snake game's target generator. Picks a new target cell

---
 rtl/snake_pkg.sv | 16 +
 rtl/snake_lfsr.sv | 28 ++
 rtl/snake_target_placer.sv | 153 +++++++++++++++
 3 files changed

// File: rtl/snake_pkg.sv
// Shared definitions for the snake playfield placers: default grid size,
// LFSR polynomial/seed and the placer state encoding.
package snake_pkg;

    localparam int          GRID_W_DEF    = 160;
    localparam int          GRID_H_DEF    = 120;
    localparam logic [15:0] LFSR_TAPS_DEF = 16'hB400;
    localparam logic [15:0] LFSR_SEED_DEF = 16'hACE1;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_DRAW = 2'd1,
        ST_WAIT = 2'd2
    } state_t;

endpackage

// File: rtl/snake_lfsr.sv
// Free-running Galois LFSR (right-shifting, feedback mask applied when the
// shifted-out bit is 1). SEED must be non-zero or the register locks up.
module snake_lfsr
    import snake_pkg::*;
#(
    parameter int           W    = 16,
    parameter logic [W-1:0] TAPS = W'(LFSR_TAPS_DEF),
    parameter logic [W-1:0] SEED = W'(LFSR_SEED_DEF)
) (
    input  logic         CLK,
    input  logic         RESET,
    input  logic         EN,
    output logic [W-1:0] STATE
);

    logic [W-1:0] r_lfsr;

    always_ff @(posedge CLK) begin
        if (RESET) begin
            r_lfsr <= SEED;
        end else if (EN) begin
            r_lfsr <= r_lfsr[0] ? ((r_lfsr >> 1) ^ TAPS) : (r_lfsr >> 1);
        end
    end

    assign STATE = r_lfsr;

endmodule

// File: rtl/snake_target_placer.sv
// Places a new snake target after each eat: draws in-grid LFSR candidates and
// vets each against the snake body through a req/ack query to the controller.
//
//   state   | meaning
//   IDLE    | target placed and valid, waiting for TARGET_REACHED
//   DRAW    | sampling LFSR candidates until one is in-grid and differs from the old target
//   WAIT    | body query outstanding; REQ and candidate held until ACK
module snake_target_placer
    import snake_pkg::*;
#(
    parameter int                GRID_W      = GRID_W_DEF,
    parameter int                GRID_H      = GRID_H_DEF,
    parameter int                LFSR_W      = 16,
    parameter logic [LFSR_W-1:0] LFSR_TAPS   = LFSR_W'(LFSR_TAPS_DEF),
    parameter logic [LFSR_W-1:0] LFSR_SEED   = LFSR_W'(LFSR_SEED_DEF),
    parameter int                MAX_RETRIES = 8,
    localparam int               X_W         = $clog2(GRID_W),
    localparam int               Y_W         = $clog2(GRID_H)
) (
    input  logic           CLK,
    input  logic           RESET,
    input  logic           TARGET_REACHED,
    output logic [X_W-1:0] TARGET_ADDR_X,
    output logic [Y_W-1:0] TARGET_ADDR_Y,
    output logic           TARGET_VALID,
    output logic           TARGET_FORCED,
    output logic           QUERY_REQ,
    output logic [X_W-1:0] QUERY_X,
    output logic [Y_W-1:0] QUERY_Y,
    input  logic           QUERY_ACK,
    input  logic           QUERY_HIT
);

    localparam int                 RETRY_W    = (MAX_RETRIES > 1) ? $clog2(MAX_RETRIES) : 1;
    localparam logic [RETRY_W-1:0] RETRY_LAST = RETRY_W'(MAX_RETRIES - 1);
    localparam logic [X_W:0]       GRID_W_L   = (X_W + 1)'(GRID_W);
    localparam logic [Y_W:0]       GRID_H_L   = (Y_W + 1)'(GRID_H);
    localparam logic [X_W-1:0]     HOME_X     = X_W'(GRID_W / 2);
    localparam logic [Y_W-1:0]     HOME_Y     = Y_W'(GRID_H / 2);

    logic [LFSR_W-1:0] w_lfsr;
    logic [X_W-1:0]    w_cx;
    logic [Y_W-1:0]    w_cy;
    logic              w_reject;
    logic              w_unused;

    state_t            r_state,  w_state_nx;
    logic [X_W-1:0]    r_tx,     w_tx_nx;
    logic [Y_W-1:0]    r_ty,     w_ty_nx;
    logic              r_valid,  w_valid_nx;
    logic              r_forced, w_forced_nx;
    logic              r_req,    w_req_nx;
    logic [X_W-1:0]    r_qx,     w_qx_nx;
    logic [Y_W-1:0]    r_qy,     w_qy_nx;
    logic [RETRY_W-1:0] r_retry, w_retry_nx;

    snake_lfsr #(
        .W    (LFSR_W),
        .TAPS (LFSR_TAPS),
        .SEED (LFSR_SEED)
    ) u_lfsr (
        .CLK   (CLK),
        .RESET (RESET),
        .EN    (1'b1),
        .STATE (w_lfsr)
    );

    assign w_cx     = w_lfsr[X_W-1:0];
    assign w_cy     = w_lfsr[X_W+Y_W-1:X_W];
    // Only X_W+Y_W bits feed the candidate; the rest just keep the sequence long.
    assign w_unused = ^w_lfsr;
    assign w_reject = ({1'b0, w_cx} >= GRID_W_L) || ({1'b0, w_cy} >= GRID_H_L)
                   || ((w_cx == r_tx) && (w_cy == r_ty));

    always_ff @(posedge CLK) begin
        if (RESET) begin
            r_state  <= ST_IDLE;
            r_tx     <= HOME_X;
            r_ty     <= HOME_Y;
            r_valid  <= 1'b1;
            r_forced <= 1'b0;
            r_req    <= 1'b0;
            r_qx     <= '0;
            r_qy     <= '0;
            r_retry  <= '0;
        end else begin
            r_state  <= w_state_nx;
            r_tx     <= w_tx_nx;
            r_ty     <= w_ty_nx;
            r_valid  <= w_valid_nx;
            r_forced <= w_forced_nx;
            r_req    <= w_req_nx;
            r_qx     <= w_qx_nx;
            r_qy     <= w_qy_nx;
            r_retry  <= w_retry_nx;
        end
    end

    always_comb begin
        w_state_nx  = r_state;
        w_tx_nx     = r_tx;
        w_ty_nx     = r_ty;
        w_valid_nx  = r_valid;
        w_forced_nx = 1'b0;
        w_req_nx    = r_req;
        w_qx_nx     = r_qx;
        w_qy_nx     = r_qy;
        w_retry_nx  = r_retry;
        case (r_state)
            ST_IDLE: begin
                if (TARGET_REACHED) begin
                    w_valid_nx = 1'b0;
                    w_retry_nx = '0;
                    w_state_nx = ST_DRAW;
                end
            end
            ST_DRAW: begin
                if (!w_reject) begin
                    w_qx_nx    = w_cx;
                    w_qy_nx    = w_cy;
                    w_req_nx   = 1'b1;
                    w_state_nx = ST_WAIT;
                end
            end
            ST_WAIT: begin
                if (QUERY_ACK) begin
                    w_req_nx = 1'b0;
                    // Out of retries: accept the body cell rather than stall the game.
                    if (!QUERY_HIT || (r_retry == RETRY_LAST)) begin
                        w_tx_nx     = r_qx;
                        w_ty_nx     = r_qy;
                        w_valid_nx  = 1'b1;
                        w_forced_nx = QUERY_HIT;
                        w_state_nx  = ST_IDLE;
                    end else begin
                        w_retry_nx = r_retry + RETRY_W'(1);
                        w_state_nx = ST_DRAW;
                    end
                end
            end
            default: w_state_nx = ST_IDLE;
        endcase
    end

    assign TARGET_ADDR_X = r_tx;
    assign TARGET_ADDR_Y = r_ty;
    assign TARGET_VALID  = r_valid;
    assign TARGET_FORCED = r_forced;
    assign QUERY_REQ     = r_req;
    assign QUERY_X       = r_qx;
    assign QUERY_Y       = r_qy;

endmodule
